// File: rtl/pfc3ph_inter_s00_axi_regs_if.sv
// AXI4-Lite bus bundle for the pfc3ph_inter S00_AXI slave port.
//   master modport: drives addresses, write data/strobes, valids and response readies.
//   slave  modport: drives address/data readies, write response and read data.
interface pfc3ph_inter_s00_axi_regs_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);
  localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [2:0]                    awprot;
  logic                          awvalid;
  logic                          awready;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]             wstrb;
  logic                          wvalid;
  logic                          wready;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                    arprot;
  logic                          arvalid;
  logic                          arready;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                    rresp;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pfc3ph_inter_s00_axi_regs.sv
// AXI4-Lite register bank for the pfc3ph_inter modulator: CTRL, DUTY_A, DUTY_B, DUTY_C.
// Ports:
//   s00_axi_aclk, s00_axi_aresetn : clock, asynchronous active-low reset
//   s00_axi                       : AXI4-Lite slave (pfc3ph_inter_s00_axi_regs_if.slave)
//   update_i                      : PWM period strobe (used only with shadowing)
//   ctrl_o, duty_*_o              : control words to the modulator
//   wr_pulse_o                    : one-cycle commit pulse, bit i = register i
// Build option: PFC3PH_SHADOW_UPDATE_EN -- outputs come from shadow flops
//   reloaded from all registers whenever update_i is high.
module pfc3ph_inter_s00_axi_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                               s00_axi_aclk,
  input  logic                               s00_axi_aresetn,
  pfc3ph_inter_s00_axi_regs_if.slave         s00_axi,
  input  logic                               update_i,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      ctrl_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      duty_a_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      duty_b_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      duty_c_o,
  output logic [3:0]                         wr_pulse_o
);
  localparam int unsigned DW          = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NUM_REGS    = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned STRB_W      = DW / 8;
  localparam int unsigned STRB_IDX_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

  w_state_t          w_state;
  r_state_t          r_state;
  logic [IDX_W-1:0]  w_idx_q;
  logic [DW-1:0]     w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic [IDX_W-1:0]  r_idx_q;
  logic [DW-1:0]     regs [NUM_REGS];

  // Every transaction completes OKAY.
  assign s00_axi.bresp = 2'b00;
  assign s00_axi.rresp = 2'b00;

  // Write channel: accept only when address and data are both valid; commit at end of W_ACK.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state         <= W_IDLE;
      w_idx_q         <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      s00_axi.awready <= 1'b0;
      s00_axi.wready  <= 1'b0;
      s00_axi.bvalid  <= 1'b0;
      wr_pulse_o      <= '0;
      regs            <= '{default: '0};
    end else begin
      wr_pulse_o <= '0;
      case (w_state)
        W_IDLE: begin
          if (s00_axi.awvalid && s00_axi.wvalid) begin
            w_idx_q         <= s00_axi.awaddr[3:2];
            w_data_q        <= s00_axi.wdata;
            w_strb_q        <= s00_axi.wstrb;
            s00_axi.awready <= 1'b1;
            s00_axi.wready  <= 1'b1;
            w_state         <= W_ACK;
          end
        end
        W_ACK: begin
          s00_axi.awready <= 1'b0;
          s00_axi.wready  <= 1'b0;
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (w_strb_q[STRB_IDX_W'(b)]) begin
              regs[w_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
            end
          end
          // Pulse fires even for an all-zero strobe: the register was addressed.
          wr_pulse_o[w_idx_q] <= 1'b1;
          s00_axi.bvalid      <= 1'b1;
          w_state             <= W_RESP;
        end
        W_RESP: begin
          if (s00_axi.bready) begin
            s00_axi.bvalid <= 1'b0;
            w_state        <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: rdata samples pre-edge register contents, so a same-edge commit is not seen.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state         <= R_IDLE;
      r_idx_q         <= '0;
      s00_axi.arready <= 1'b0;
      s00_axi.rvalid  <= 1'b0;
      s00_axi.rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s00_axi.arvalid) begin
            r_idx_q         <= s00_axi.araddr[3:2];
            s00_axi.arready <= 1'b1;
            r_state         <= R_ACK;
          end
        end
        R_ACK: begin
          s00_axi.arready <= 1'b0;
          s00_axi.rdata   <= regs[r_idx_q];
          s00_axi.rvalid  <= 1'b1;
          r_state         <= R_DATA;
        end
        R_DATA: begin
          if (s00_axi.rready) begin
            s00_axi.rvalid <= 1'b0;
            r_state        <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef PFC3PH_SHADOW_UPDATE_EN
  logic [DW-1:0] shadow [NUM_REGS];

  // Shadows take the pre-edge registers, so a commit coincident with update_i waits for the next strobe.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      shadow <= '{default: '0};
    end else if (update_i) begin
      shadow <= regs;
    end
  end

  assign ctrl_o   = shadow[0];
  assign duty_a_o = shadow[1];
  assign duty_b_o = shadow[2];
  assign duty_c_o = shadow[3];

  logic unused_bits;
  assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                         s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};
`else
  assign ctrl_o   = regs[0];
  assign duty_a_o = regs[1];
  assign duty_b_o = regs[2];
  assign duty_c_o = regs[3];

  logic unused_bits;
  assign unused_bits = ^{update_i, s00_axi.awprot, s00_axi.arprot,
                         s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};
`endif

endmodule

// File: tb/tb_pfc3ph_inter_s00_axi_regs.sv
// Directed self-checking bench for pfc3ph_inter_s00_axi_regs.
module tb_pfc3ph_inter_s00_axi_regs;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned TMO = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          update_i;
  logic [DW-1:0] ctrl_o, duty_a_o, duty_b_o, duty_c_o;
  logic [3:0]    wr_pulse_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  pfc3ph_inter_s00_axi_regs_if #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) axi ();

  pfc3ph_inter_s00_axi_regs #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi         (axi.slave),
    .update_i        (update_i),
    .ctrl_o          (ctrl_o),
    .duty_a_o        (duty_a_o),
    .duty_b_o        (duty_b_o),
    .duty_c_o        (duty_c_o),
    .wr_pulse_o      (wr_pulse_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_start(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    axi.awaddr  = addr;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
  endtask

  // Completes a started write; optionally leaves B pending or strobes update_i on the commit edge.
  task automatic wr_finish(input bit hold_b, input bit strobe,
                           output logic [3:0] pulse, output logic [1:0] resp);
    int unsigned n = 0;
    pulse = '0;
    resp  = 2'b11;
    while (!axi.awready && n < TMO) begin
      tick();
      n++;
    end
    if (!axi.awready) begin
      check("aw_handshake_timeout", 32'(axi.awready), 32'd1);
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      return;
    end
    if (strobe) update_i = 1'b1;
    tick();
    update_i    = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    pulse = wr_pulse_o;
    resp  = axi.bresp;
    if (!hold_b) begin
      axi.bready = 1'b1;
      n = 0;
      while (axi.bvalid && n < TMO) begin
        tick();
        n++;
      end
      check("b_complete", 32'(axi.bvalid), 32'd0);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [3:0] pulse, output logic [1:0] resp);
    wr_start(addr, data, strb);
    wr_finish(1'b0, 1'b0, pulse, resp);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int unsigned n = 0;
    data = '0;
    resp = 2'b11;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b1;
    while (!axi.arready && n < TMO) begin
      tick();
      n++;
    end
    if (!axi.arready) begin
      check("ar_handshake_timeout", 32'(axi.arready), 32'd1);
      axi.arvalid = 1'b0;
      return;
    end
    tick();
    axi.arvalid = 1'b0;
    check("rvalid_after_ar", 32'(axi.rvalid), 32'd1);
    data = axi.rdata;
    resp = axi.rresp;
    tick();
  endtask

  task automatic pulse_update();
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  pulse;
    logic [1:0]  resp;
    logic [31:0] rd;
    int unsigned bad;

    rst_n = 1'b0;
    update_i = 1'b0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0;  axi.wstrb = '0;  axi.wvalid = 1'b0;
    axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_bvalid",  32'(axi.bvalid),  32'd0);
    check("rst_rvalid",  32'(axi.rvalid),  32'd0);
    check("rst_rdata",   axi.rdata,        32'd0);
    check("rst_pulse",   32'(wr_pulse_o),  32'd0);
    check("rst_ctrl_o",  ctrl_o,           32'd0);
    rst_n = 1'b1;
    tick();

    // Shadow behaviour (or pass-through when shadowing is not built in)
    axi_write(4'h4, 32'h100, 4'hF, pulse, resp);
`ifdef PFC3PH_SHADOW_UPDATE_EN
    check("sh_before_strobe", duty_a_o, 32'h0);
    pulse_update();
    check("sh_after_strobe", duty_a_o, 32'h100);
    wr_start(4'h4, 32'h200, 4'hF);
    wr_finish(1'b0, 1'b1, pulse, resp);
    check("sh_same_edge_old", duty_a_o, 32'h100);
    pulse_update();
    check("sh_next_strobe", duty_a_o, 32'h200);
`else
    check("pt_direct", duty_a_o, 32'h100);
    pulse_update();
    check("pt_update_ignored", duty_a_o, 32'h100);
`endif

    // Four-register write/read-back
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, pulse, resp);
      check($sformatf("t1_pulse%0d", i), 32'(pulse), 32'(1 << i));
      check($sformatf("t1_bresp%0d", i), 32'(resp), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, resp);
      check($sformatf("t1_rdata%0d", i), rd, 32'(i + 1));
      check($sformatf("t1_rresp%0d", i), 32'(resp), 32'd0);
    end
`ifdef PFC3PH_SHADOW_UPDATE_EN
    check("t1_ctrl_o_pre", ctrl_o, 32'h0);
`else
    check("t1_ctrl_o_pre", ctrl_o, 32'h1);
`endif
    pulse_update();
    check("t1_ctrl_o",   ctrl_o,   32'h1);
    check("t1_duty_a_o", duty_a_o, 32'h2);
    check("t1_duty_b_o", duty_b_o, 32'h3);
    check("t1_duty_c_o", duty_c_o, 32'h4);

    // Byte strobes, and an all-zero strobe
    axi_write(4'h4, 32'h11111111, 4'hF, pulse, resp);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101, pulse, resp);
    axi_read(4'h4, rd, resp);
    check("t2_strb0101", rd, 32'h11BB11DD);
    axi_write(4'h4, 32'hFFFFFFFF, 4'h0, pulse, resp);
    check("t2_strb0_pulse", 32'(pulse), 32'b0010);
    check("t2_strb0_bresp", 32'(resp), 32'd0);
    axi_read(4'h4, rd, resp);
    check("t2_strb0_data", rd, 32'h11BB11DD);

    // Address valid five cycles ahead of data valid
    axi.awaddr  = 4'h8;
    axi.wdata   = 32'hCAFE0003;
    axi.wstrb   = 4'hF;
    axi.awvalid = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (axi.awready || axi.wready || wr_pulse_o != 4'b0) bad++;
    end
    check("t3_aw_alone", bad, 32'd0);
    axi.wvalid = 1'b1;
    wr_finish(1'b0, 1'b0, pulse, resp);
    check("t3_pulse", 32'(pulse), 32'b0100);
    tick();
    check("t3_single_commit", 32'(wr_pulse_o), 32'd0);
    axi_read(4'h8, rd, resp);
    check("t3_rdata", rd, 32'hCAFE0003);

    // Stalled write response blocks a second write
    axi.bready = 1'b0;
    wr_start(4'h8, 32'h55, 4'hF);
    wr_finish(1'b1, 1'b0, pulse, resp);
    check("t4_first_pulse", 32'(pulse), 32'b0100);
    wr_start(4'hC, 32'h66, 4'hF);
    bad = 0;
    repeat (10) begin
      tick();
      if (!axi.bvalid || axi.awready || axi.wready || wr_pulse_o != 4'b0) bad++;
    end
    check("t4_b_stall", bad, 32'd0);
    axi.bready = 1'b1;
    wr_finish(1'b0, 1'b0, pulse, resp);
    check("t4_second_pulse", 32'(pulse), 32'b1000);
    axi_read(4'h8, rd, resp);
    check("t4_rd8", rd, 32'h55);
    axi_read(4'hC, rd, resp);
    check("t4_rdC", rd, 32'h66);

    // Reset during write response
    axi.bready = 1'b0;
    wr_start(4'h0, 32'hDEAD, 4'hF);
    wr_finish(1'b1, 1'b0, pulse, resp);
    check("t6_bvalid_pre", 32'(axi.bvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_bvalid_async", 32'(axi.bvalid), 32'd0);
    check("t6_ctrl_o_async", ctrl_o, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, resp);
      check($sformatf("t6_rd%0d", i), rd, 32'd0);
    end
    check("t6_duty_a_o", duty_a_o, 32'd0);
    check("t6_duty_c_o", duty_c_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
